// File: rtl/key_scan_encoder.sv
// Debounced, priority-encoded keypad scanner with a one-entry event register.
// Define KEY_REPEAT_EN to add auto-repeat events while a key stays held.
module key_scan_encoder #(
    parameter int N_KEYS        = 10,
    parameter int DEB_CYCLES    = 4,
    parameter int REPEAT_CYCLES = 16,
    localparam int CODE_W       = $clog2(N_KEYS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_KEYS-1:0] S_n,
    output logic              ev_valid,
    input  logic              ev_ready,
    output logic [CODE_W-1:0] ev_code,
    output logic              ev_repeat,
    output logic              GS,
    output logic [CODE_W-1:0] L,
    output logic              ovf
);

    localparam int DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [DEB_W-1:0] DEB_MAX = DEB_W'(DEB_CYCLES - 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] HELD = 1'b1;

    // Out-of-range parameters stop elaboration rather than building odd hardware.
    if (N_KEYS < 2 || N_KEYS > 64 || DEB_CYCLES < 1 || REPEAT_CYCLES < 2) begin : g_param_check
        $error("key_scan_encoder: illegal parameter value");
    end

    logic [N_KEYS-1:0] sync1_q;
    logic [N_KEYS-1:0] sync2_q;
    logic [N_KEYS-1:0] pressed;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= S_n;
            sync2_q <= sync1_q;
        end
    end

    for (genvar gi = 0; gi < N_KEYS; gi++) begin : g_key
        assign pressed[gi] = ~sync2_q[gi];
    end

    // Ascending scan so the highest pressed index overwrites lower ones.
    logic [CODE_W-1:0] cand_code;
    always_comb begin
        cand_code = '0;
        for (int i = 0; i < N_KEYS; i++) begin
            if (pressed[i]) cand_code = CODE_W'(i);
        end
    end

    logic [CODE_W:0] cand;
    assign cand = {|pressed, cand_code};

    logic [CODE_W:0] cand_q, cand_d;
    logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
    logic             deb_accept;

    always_comb begin
        cand_d    = cand_q;
        deb_cnt_d = deb_cnt_q;
        if (cand != cand_q) begin
            cand_d    = cand;
            deb_cnt_d = '0;
        end else if (deb_cnt_q != DEB_MAX) begin
            deb_cnt_d = deb_cnt_q + 1'b1;
        end
    end

    // Stays asserted once stable; the FSM only reacts when it differs from its state.
    assign deb_accept = (cand == cand_q) && (deb_cnt_q == DEB_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            cand_q    <= '0;
            deb_cnt_q <= '0;
        end else begin
            cand_q    <= cand_d;
            deb_cnt_q <= deb_cnt_d;
        end
    end

    logic [0:0]        state_q, state_d;
    logic [CODE_W-1:0] held_q, held_d;
    logic              emit;
    logic [CODE_W-1:0] emit_code;
    logic              emit_rep;

`ifdef KEY_REPEAT_EN
    localparam int REP_W = $clog2(REPEAT_CYCLES);
    localparam logic [REP_W-1:0] REP_MAX = REP_W'(REPEAT_CYCLES - 1);
    logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
`endif

    always_comb begin
        state_d   = state_q;
        held_d    = held_q;
        emit      = 1'b0;
        emit_code = cand_q[CODE_W-1:0];
        emit_rep  = 1'b0;
`ifdef KEY_REPEAT_EN
        rep_cnt_d = rep_cnt_q;
`endif
        if (deb_accept && cand_q[CODE_W] &&
            (state_q == IDLE || held_q != cand_q[CODE_W-1:0])) begin
            emit    = 1'b1;
            state_d = HELD;
            held_d  = cand_q[CODE_W-1:0];
`ifdef KEY_REPEAT_EN
            rep_cnt_d = '0;
`endif
        end else if (deb_accept && !cand_q[CODE_W] && state_q == HELD) begin
            state_d = IDLE;
            held_d  = '0;
`ifdef KEY_REPEAT_EN
            rep_cnt_d = '0;
`endif
        end
`ifdef KEY_REPEAT_EN
        else if (state_q == HELD) begin
            if (rep_cnt_q == REP_MAX) begin
                emit      = 1'b1;
                emit_rep  = 1'b1;
                emit_code = held_q;
                rep_cnt_d = '0;
            end else begin
                rep_cnt_d = rep_cnt_q + 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            held_q  <= '0;
        end else begin
            state_q <= state_d;
            held_q  <= held_d;
        end
    end

`ifdef KEY_REPEAT_EN
    always_ff @(posedge clk) begin
        if (rst) rep_cnt_q <= '0;
        else     rep_cnt_q <= rep_cnt_d;
    end
`endif

    logic              ev_valid_q, ev_valid_d;
    logic [CODE_W-1:0] ev_code_q, ev_code_d;
    logic              ev_rep_q, ev_rep_d;
    logic              ovf_q, ovf_d;

    // A handshake in the same cycle frees the slot, so the new event replaces it.
    always_comb begin
        ev_valid_d = ev_valid_q;
        ev_code_d  = ev_code_q;
        ev_rep_d   = ev_rep_q;
        ovf_d      = ovf_q;
        if (emit) begin
            if (!ev_valid_q || ev_ready) begin
                ev_valid_d = 1'b1;
                ev_code_d  = emit_code;
                ev_rep_d   = emit_rep;
            end else begin
                ovf_d = 1'b1;
            end
        end else if (ev_valid_q && ev_ready) begin
            ev_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ev_valid_q <= 1'b0;
            ev_code_q  <= '0;
            ev_rep_q   <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            ev_valid_q <= ev_valid_d;
            ev_code_q  <= ev_code_d;
            ev_rep_q   <= ev_rep_d;
            ovf_q      <= ovf_d;
        end
    end

    assign ev_valid  = ev_valid_q;
    assign ev_code   = ev_code_q;
    assign ev_repeat = ev_rep_q;
    assign ovf       = ovf_q;
    assign GS        = (state_q == HELD);
    assign L         = held_q;

endmodule

// File: doc/key_scan_encoder.md
KEY_SCAN_ENCODER -- requirements
Module: key_scan_encoder

Interface
REQ-001 SHALL have parameter N_KEYS, default 10: number of active-low key inputs, legal 2..64.
REQ-002 SHALL have parameter DEB_CYCLES, default 4: debounce stability window in clocks, legal >= 1.
REQ-003 SHALL have parameter REPEAT_CYCLES, default 16: auto-repeat interval in clocks, legal >= 2.
REQ-004 SHALL derive localparam CODE_W = $clog2(N_KEYS).
REQ-005 SHALL have port clk, input, 1: single clock, all logic on rising edge.
REQ-006 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-007 SHALL have port S_n, input, N_KEYS: raw asynchronous keys, 0 = pressed.
REQ-008 SHALL have port ev_valid, output, 1: key event pending.
REQ-009 SHALL have port ev_ready, input, 1: consumer accepts event.
REQ-010 SHALL have port ev_code, output, CODE_W: key index of pending event.
REQ-011 SHALL have port ev_repeat, output, 1: pending event is an auto-repeat.
REQ-012 SHALL have port GS, output, 1: a debounced key is held.
REQ-013 SHALL have port L, output, CODE_W: debounced held key index, 0 when GS=0.
REQ-014 SHALL have port ovf, output, 1: sticky event-overflow flag.

Function
REQ-015 SHALL pass S_n through a 2-flop synchroniser before any use.
REQ-016 SHALL priority-encode synchronised keys: highest pressed index wins; candidate = {any_pressed, code}.
REQ-017 SHALL accept a candidate as debounced only when unchanged for DEB_CYCLES consecutive edges; any change restarts the window.
REQ-018 SHALL update GS/L/ev_valid on edge k0+2+DEB_CYCLES, where k0 is the first edge sampling the new steady S_n.
REQ-019 SHALL implement FSM IDLE (nothing held) and HELD (key held).
REQ-020 SHALL, IDLE->HELD on debounced press: emit event, code = debounced index, ev_repeat=0.
REQ-021 SHALL, HELD->HELD on debounced change to a different index: emit event with new code, ev_repeat=0.
REQ-022 SHALL, HELD->IDLE on debounced release of all keys: emit no event.
REQ-023 SHALL hold a one-entry event register: ev_valid set on emit, cleared on ev_valid && ev_ready.
REQ-024 SHALL keep ev_code/ev_repeat stable while ev_valid=1 and ev_ready=0.
REQ-025 SHALL, on emit in the same cycle as a completed handshake, load the new event; ev_valid stays 1.
REQ-026 SHALL, on emit while ev_valid=1 and ev_ready=0, drop the new event, keep the old one, and set ovf until reset.
REQ-027 SHALL ignore glitches shorter than DEB_CYCLES clocks: no change in GS, L or events.

Reset
REQ-028 SHALL, while rst=1 at an edge, force FSM=IDLE, ev_valid=0, ev_code=0, ev_repeat=0, GS=0, L=0, ovf=0, counters=0, synchroniser flops all-ones.
REQ-029 SHALL discard any pending event on reset mid-operation; a key still held is re-detected as a new press with full REQ-018 latency after rst falls.

Configuration
REQ-030 SHALL, with KEY_REPEAT_EN defined: in HELD, count clocks since the last event for the held key; at REPEAT_CYCLES emit an event (same code, ev_repeat=1) and restart the count; a key change or release restarts or stops it.
REQ-031 SHALL, without KEY_REPEAT_EN: omit the repeat counter, tie ev_repeat to 0, and ignore REPEAT_CYCLES.

Verification (N_KEYS=10, DEB_CYCLES=4, REPEAT_CYCLES=16)
REQ-032 SHALL check: S_n[3]=0 steady from edge 0, ev_ready=1 -> ev_valid=1, ev_code=3, ev_repeat=0 after edge 6; GS=1, L=3.
REQ-033 SHALL check: keys 2 and 7 pressed together -> single event ev_code=7; release of 7 with 2 held -> event ev_code=2 after debounce.
REQ-034 SHALL check: 3-cycle low pulse on S_n[5] -> no event, GS stays 0.
REQ-035 SHALL check: ev_ready=0, press 1, release, then press 4 -> ev_code stays 1, ovf=1; ev_ready=1 -> one handshake, ev_valid=0.
REQ-036 SHALL check with KEY_REPEAT_EN: key 9 held 60 cycles, ev_ready=1 -> one press event, then ev_repeat=1 events every 16 cycles; without the macro, exactly one event.
REQ-037 SHALL check: rst=1 for 1 cycle while key 6 is held and an event is pending -> all outputs 0; new ev_code=6 after edge 6 post-reset.
